// File: rtl/zf_pkg.sv
// ---------------------------------------------------------------------------
// zf_pkg
// Shared definitions for the ZF 16-QAM slicer slice:
//   - default element width / fractional bits of the ZF fixed-point result
//   - PAM4 Gray label constants
//   - slicer FSM state encoding
//   - element / column index constants and the symbol -> element mapping
// Optional feature macro used by the files importing this package:
//   ZF_CLIP_FLAG_EN
// ---------------------------------------------------------------------------
package zf_pkg;

   localparam int W         = 32;
   localparam int FRAC_BITS = 16;

   localparam int N_ELEM       = 8;
   localparam int ELEM_PER_COL = 4;
   localparam int N_SYM        = 4;

   // Column indices inside Q_processed
   localparam int COL0 = 0;
   localparam int COL1 = 1;

   // Element indices inside a column (e0 is the MSB word)
   localparam int E_RE_X1 = 0;
   localparam int E_RE_X2 = 1;
   localparam int E_IM_X1 = 2;
   localparam int E_IM_X2 = 3;

   // PAM4 Gray labels
   localparam logic [1:0] L_M3 = 2'b00;
   localparam logic [1:0] L_M1 = 2'b01;
   localparam logic [1:0] L_P1 = 2'b11;
   localparam logic [1:0] L_P3 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLICE = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   // Symbol idx bit 1 selects the column, bit 0 selects stream x1/x2.
   // The I part comes from the real element, the Q part from the imaginary one.
   function automatic logic [2:0] i_elem(input logic [1:0] idx);
      int col;
      col = idx[1] ? COL1 : COL0;
      return 3'(col * ELEM_PER_COL + (idx[0] ? E_RE_X2 : E_RE_X1));
   endfunction

   function automatic logic [2:0] q_elem(input logic [1:0] idx);
      int col;
      col = idx[1] ? COL1 : COL0;
      return 3'(col * ELEM_PER_COL + (idx[0] ? E_IM_X2 : E_IM_X1));
   endfunction

endpackage

// File: rtl/pam4_slicer.sv
// ---------------------------------------------------------------------------
// pam4_slicer
// Combinational decision of one signed fixed-point element into a PAM4 Gray
// label, thresholds at 0 and +/-2.0.
// Ports:
//   v      in  W    signed element, FRAC_BITS fractional bits
//   label  out 2    Gray label (00=-3, 01=-1, 11=+1, 10=+3)
//   clip   out 1    |v| >= 4.0 (only with ZF_CLIP_FLAG_EN)
// Optional feature macro: ZF_CLIP_FLAG_EN
// ---------------------------------------------------------------------------
module pam4_slicer #(
   parameter int W         = zf_pkg::W,
   parameter int FRAC_BITS = zf_pkg::FRAC_BITS
) (
   input  logic signed [W-1:0] v,
   output logic        [1:0]   label
`ifdef ZF_CLIP_FLAG_EN
   ,
   output logic                clip
`endif
);
   import zf_pkg::*;

   localparam longint             T_L   = longint'(2) << FRAC_BITS;
   localparam logic signed [W-1:0] T_POS = W'(T_L);
   localparam logic signed [W-1:0] T_NEG = -T_POS;

   always_comb begin
      label = L_P1;
      if (v < T_NEG) begin
         label = L_M3;
      end else if (v[W-1]) begin
         label = L_M1;
      end else if (v < T_POS) begin
         label = L_P1;
      end else begin
         label = L_P3;
      end
   end

`ifdef ZF_CLIP_FLAG_EN
   // Two-sided compare instead of abs(): the most-negative value has no
   // positive counterpart but is still below -4.0, so it clips naturally.
   localparam longint             C_L   = longint'(4) << FRAC_BITS;
   localparam logic signed [W-1:0] C_POS = W'(C_L);
   localparam logic signed [W-1:0] C_NEG = -C_POS;

   always_comb begin
      clip = (v >= C_POS) || (v <= C_NEG);
   end
`endif

endmodule

// File: rtl/zf_qam16_slicer.sv
// ---------------------------------------------------------------------------
// zf_qam16_slicer
// Takes one 2x2 ZF Q_processed result, slices its 8 real elements to PAM4
// labels and streams four Gray-coded 16-QAM symbols.
// Ports:
//   clk         in   1    system clock, rising edge
//   reset       in   1    asynchronous active-high reset
//   ready_in    in   1    upstream result valid
//   accept_out  out  1    block can take a result (IDLE)
//   q_in        in   8W   column 0 in [8W-1:4W], column 1 in [4W-1:0]
//   sym_valid   out  1    symbol valid
//   sym_ready   in   1    downstream accepts symbol
//   sym         out  4    {I label, Q label}
//   sym_idx     out  2    symbol index in block
//   sym_last    out  1    high on sym_idx == 3
//   clip_flag   out  1    erasure candidate (only with ZF_CLIP_FLAG_EN)
// Optional feature macro: ZF_CLIP_FLAG_EN
// ---------------------------------------------------------------------------
module zf_qam16_slicer #(
   parameter int W         = zf_pkg::W,
   parameter int FRAC_BITS = zf_pkg::FRAC_BITS
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ready_in,
   output logic           accept_out,
   input  logic [8*W-1:0] q_in,
   output logic           sym_valid,
   input  logic           sym_ready,
   output logic [3:0]     sym,
   output logic [1:0]     sym_idx,
   output logic           sym_last
`ifdef ZF_CLIP_FLAG_EN
   ,
   output logic           clip_flag
`endif
);
   import zf_pkg::*;

   localparam logic [1:0] LAST_IDX = 2'(N_SYM - 1);

   state_t           state_reg;
   logic [8*W-1:0]   q_reg;
   logic [1:0]       label_w   [N_ELEM];
   logic [1:0]       label_reg [N_ELEM];
   logic [1:0]       sym_idx_next;
`ifdef ZF_CLIP_FLAG_EN
   logic             clip_w    [N_ELEM];
   logic             clip_reg  [N_ELEM];
`endif

   assign sym_idx_next = sym_idx + 2'd1;

   // Element gi sits at word (N_ELEM-1-gi) counting from the LSB end.
   generate
      for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slice
         pam4_slicer #(
            .W         (W),
            .FRAC_BITS (FRAC_BITS)
         ) u_slicer (
            .v     (q_reg[(N_ELEM-gi)*W-1 -: W]),
            .label (label_w[gi])
`ifdef ZF_CLIP_FLAG_EN
            ,
            .clip  (clip_w[gi])
`endif
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         accept_out <= 1'b1;
         sym_valid  <= 1'b0;
         sym        <= 4'd0;
         sym_idx    <= 2'd0;
         sym_last   <= 1'b0;
         q_reg      <= '0;
         for (int i = 0; i < N_ELEM; i++) begin
            label_reg[i] <= 2'b00;
`ifdef ZF_CLIP_FLAG_EN
            clip_reg[i]  <= 1'b0;
`endif
         end
`ifdef ZF_CLIP_FLAG_EN
         clip_flag  <= 1'b0;
`endif
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (ready_in) begin
                  q_reg      <= q_in;
                  accept_out <= 1'b0;
                  state_reg  <= ST_SLICE;
               end
            end
            ST_SLICE: begin
               for (int i = 0; i < N_ELEM; i++) begin
                  label_reg[i] <= label_w[i];
`ifdef ZF_CLIP_FLAG_EN
                  clip_reg[i]  <= clip_w[i];
`endif
               end
               // Symbol 0 is presented straight from the slicer outputs so
               // the first beat does not wait for the label registers.
               sym       <= {label_w[i_elem(2'd0)], label_w[q_elem(2'd0)]};
               sym_idx   <= 2'd0;
               sym_last  <= 1'b0;
               sym_valid <= 1'b1;
`ifdef ZF_CLIP_FLAG_EN
               clip_flag <= clip_w[i_elem(2'd0)] | clip_w[q_elem(2'd0)];
`endif
               state_reg <= ST_SEND;
            end
            ST_SEND: begin
               if (sym_ready) begin
                  if (sym_idx == LAST_IDX) begin
                     sym_valid  <= 1'b0;
                     sym        <= 4'd0;
                     sym_idx    <= 2'd0;
                     sym_last   <= 1'b0;
                     accept_out <= 1'b1;
`ifdef ZF_CLIP_FLAG_EN
                     clip_flag  <= 1'b0;
`endif
                     state_reg  <= ST_IDLE;
                  end else begin
                     sym_idx  <= sym_idx_next;
                     sym      <= {label_reg[i_elem(sym_idx_next)],
                                  label_reg[q_elem(sym_idx_next)]};
                     sym_last <= (sym_idx_next == LAST_IDX);
`ifdef ZF_CLIP_FLAG_EN
                     clip_flag <= clip_reg[i_elem(sym_idx_next)] |
                                  clip_reg[q_elem(sym_idx_next)];
`endif
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zf_qam16_slicer.sv
// ---------------------------------------------------------------------------
// tb_zf_qam16_slicer
// Directed bench for zf_qam16_slicer with a cycle-level behavioural model.
// Optional feature macro: ZF_CLIP_FLAG_EN
// ---------------------------------------------------------------------------
module tb_zf_qam16_slicer;

   localparam int ONE = 65536;
`ifdef ZF_CLIP_FLAG_EN
   localparam logic CLIP_ON = 1'b1;
`else
   localparam logic CLIP_ON = 1'b0;
`endif

   typedef int         blk_t  [8];
   typedef logic [6:0] exp4_t [4];

   logic         clk = 1'b0;
   logic         reset;
   logic         ready_in;
   logic         accept_out;
   logic [255:0] q_in;
   logic         sym_valid;
   logic         sym_ready;
   logic [3:0]   sym;
   logic [1:0]   sym_idx;
   logic         sym_last;
   logic         clip_bit;
`ifdef ZF_CLIP_FLAG_EN
   logic         clip_flag;
   assign clip_bit = clip_flag;
`else
   assign clip_bit = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zf_qam16_slicer dut (
      .clk        (clk),
      .reset      (reset),
      .ready_in   (ready_in),
      .accept_out (accept_out),
      .q_in       (q_in),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .sym        (sym),
      .sym_idx    (sym_idx),
      .sym_last   (sym_last)
`ifdef ZF_CLIP_FLAG_EN
      ,
      .clip_flag  (clip_flag)
`endif
   );

   // ------------------------------------------------------------------ model
   function automatic logic [255:0] pack_blk(input blk_t b);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[(8-k)*32-1 -: 32] = b[k];
      return r;
   endfunction

   function automatic logic [1:0] m_slice(input int v);
      if (v < -2*ONE) return 2'b00;
      if (v < 0)      return 2'b01;
      if (v < 2*ONE)  return 2'b11;
      return 2'b10;
   endfunction

   function automatic logic m_clip(input int v);
      longint a;
      a = (v < 0) ? -longint'(v) : longint'(v);
      return a >= longint'(4*ONE);
   endfunction

   int i_of [4] = '{0, 1, 4, 5};
   int q_of [4] = '{2, 3, 6, 7};

   logic m_busy    = 1'b0;
   logic m_slicing = 1'b0;
   int   m_beat    = 0;
   int   m_caps    = 0;
   int   m_blk [8];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy    <= 1'b0;
         m_slicing <= 1'b0;
         m_beat    <= 0;
      end else if (!m_busy) begin
         if (ready_in) begin
            m_busy    <= 1'b1;
            m_slicing <= 1'b1;
            m_beat    <= 0;
            m_caps    <= m_caps + 1;
            for (int k = 0; k < 8; k++) m_blk[k] <= $signed(q_in[(8-k)*32-1 -: 32]);
         end
      end else if (m_slicing) begin
         m_slicing <= 1'b0;
      end else if (sym_ready) begin
         if (m_beat == 3) begin
            m_busy <= 1'b0;
            m_beat <= 0;
         end else begin
            m_beat <= m_beat + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout", name);
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic exp_valid;
      exp_valid = m_busy && !m_slicing;
      chk("accept_out", {31'd0, accept_out}, {31'd0, !m_busy});
      chk("sym_valid", {31'd0, sym_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         chk("sym", {28'd0, sym},
             {28'd0, m_slice(m_blk[i_of[m_beat]]), m_slice(m_blk[q_of[m_beat]])});
         chk("sym_idx", {30'd0, sym_idx}, 32'(m_beat));
         chk("sym_last", {31'd0, sym_last}, {31'd0, m_beat == 3});
`ifdef ZF_CLIP_FLAG_EN
         chk("clip_flag", {31'd0, clip_flag},
             {31'd0, m_clip(m_blk[i_of[m_beat]]) || m_clip(m_blk[q_of[m_beat]])});
`endif
      end
   end

   // Accepted-beat log, one line per transaction
   logic [6:0] log_q [$];
   always @(posedge clk) begin
      if (!reset && sym_valid && sym_ready) begin
         log_q.push_back({clip_bit, sym_idx, sym});
         $display("beat idx=%0d sym=%b last=%b clip=%b", sym_idx, sym, sym_last, clip_bit);
      end
   end

   task automatic check_log(input string name, input exp4_t e);
      if (log_q.size() < 4) begin
         timeout({name, " beat count"});
         log_q.delete();
      end else begin
         for (int i = 0; i < 4; i++) chk(name, 32'(log_q.pop_front()), 32'(e[i]));
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (m_busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (m_busy) timeout(name);
   endtask

   task automatic wait_beat(input int b, input string name);
      int n;
      n = 0;
      while (!(m_busy && !m_slicing && m_beat == b) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) timeout(name);
   endtask

   task automatic send(input blk_t b);
      @(negedge clk);
      q_in     = pack_blk(b);
      ready_in = 1'b1;
      @(negedge clk);
      ready_in = 1'b0;
   endtask

   // ------------------------------------------------------------- stimulus
   blk_t  nominal, thresh, clipblk;
   exp4_t e_nom, e_thr, e_clip;

   initial begin
      int lat;
      int c0;
      int n;
      nominal = '{ONE, -3*ONE, -ONE, 3*ONE, 3*ONE, ONE, -3*ONE, -ONE};
      thresh  = '{0, 2*ONE, -2*ONE, -2*ONE-1, 2*ONE-1, -1, 3*ONE, -3*ONE};
      clipblk = '{4*ONE, 261488, 0, 0, int'(32'h8000_0000), 0, 0, 0};
      e_nom   = '{7'b0001101, 7'b0010010, 7'b0101000, 7'b0111101};
      e_thr   = '{7'b0001101, 7'b0011000, 7'b0101110, 7'b0110100};
      e_clip  = '{{CLIP_ON, 6'b001011}, 7'b0011011, {CLIP_ON, 6'b100011}, 7'b0111111};

      reset     = 1'b1;
      ready_in  = 1'b0;
      sym_ready = 1'b1;
      q_in      = '0;

      // Pin the model to hand-computed thresholds
      chk("model slice 0", {30'd0, m_slice(0)}, 32'h3);
      chk("model slice -T", {30'd0, m_slice(-2*ONE)}, 32'h1);
      chk("model slice +T", {30'd0, m_slice(2*ONE)}, 32'h2);
      chk("model slice -T-1", {30'd0, m_slice(-2*ONE-1)}, 32'h0);
      chk("model clip min", {31'd0, m_clip(int'(32'h8000_0000))}, 32'h1);
      chk("model clip 3.99", {31'd0, m_clip(261488)}, 32'h0);

      repeat (3) @(negedge clk);
      chk("reset accept_out", {31'd0, accept_out}, 32'h1);
      chk("reset sym_valid", {31'd0, sym_valid}, 32'h0);
      chk("reset sym", {28'd0, sym}, 32'h0);
      chk("reset sym_idx", {30'd0, sym_idx}, 32'h0);
      chk("reset sym_last", {31'd0, sym_last}, 32'h0);
      reset = 1'b0;

      // Nominal block with latency measurement
      @(negedge clk);
      q_in     = pack_blk(nominal);
      ready_in = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      ready_in = 1'b0;
      while (!sym_valid && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'd2);
      wait_idle("nominal");
      check_log("nominal", e_nom);

      // Threshold block
      send(thresh);
      wait_idle("thresh");
      check_log("thresh", e_thr);

      // Backpressure at idx1 for 5 cycles
      send(nominal);
      wait_beat(1, "bp reach idx1");
      sym_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp sym", {28'd0, sym}, 32'b0010);
         chk("bp sym_idx", {30'd0, sym_idx}, 32'd1);
      end
      sym_ready = 1'b1;
      wait_idle("backpressure");
      check_log("backpressure", e_nom);

      // Back-to-back with ready_in held high
      @(negedge clk);
      c0       = m_caps;
      q_in     = pack_blk(nominal);
      ready_in = 1'b1;
      n = 0;
      while (m_caps != c0 + 1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) timeout("b2b first capture");
      q_in = pack_blk(thresh);
      n = 0;
      while (m_caps != c0 + 2 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) timeout("b2b second capture");
      ready_in = 1'b0;
      wait_idle("b2b");
      check_log("b2b first", e_nom);
      check_log("b2b second", e_thr);

      // Reset in the middle of SEND at idx2
      send(thresh);
      wait_beat(2, "rst reach idx2");
      #2 reset = 1'b1;
      #1;
      chk("rst sym_valid", {31'd0, sym_valid}, 32'h0);
      chk("rst sym_idx", {30'd0, sym_idx}, 32'h0);
      chk("rst accept_out", {31'd0, accept_out}, 32'h1);
      @(negedge clk);
      #2 reset = 1'b0;
      log_q.delete();
      send(nominal);
      wait_idle("after reset");
      check_log("after reset", e_nom);

      // Clip / most-negative element block
      send(clipblk);
      wait_idle("clip");
      check_log("clip", e_clip);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
